fir_interpolator: RTL and testbench
===================================

Name: fir_interpolator

Overview:
- Anti-imaging interpolation FIR; the counterpart of the decimating FIR filter in the DFE filter array.
- Accepts one input sample and emits L output samples. L is selectable from 1, 2, 4, 8 and 16.
- Uses a polyphase structure with a single time-multiplexed MAC.
- Sits between the upstream sample source and the DAC-side chain. Coefficients are loaded at run time through a write port.

Parameters:
- WIDTH, 16, input sample width (signed).
- COEFF_WIDTH, 16, coefficient width (signed).
- N, 64, total prototype taps; power of two, at least 16.
- ACC_WIDTH, 41, accumulator and output width (signed).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- L_sel  in  5  interpolation factor request; sampled only on input acceptance.
- coeff_we  in  1  coefficient write strobe.
- coeff_addr  in  log2(N)  coefficient index h[k].
- coeff_data  in  COEFF_WIDTH  coefficient value (signed).
- x_input  in  WIDTH  input sample (signed).
- valid_in  in  1  x_input valid.
- ready_in  out  1  block can accept a sample.
- y_output  out  ACC_WIDTH  output sample (signed, registered).
- valid_out  out  1  one-cycle strobe qualifying y_output.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation): clears the following.
  - y_output=0, valid_out=0.
  - Delay line d[0..N-1]=0 and coefficient memory h[0..N-1]=0.
  - Accumulator, phase and tap counters = 0; latched L=1; state=IDLE.
  - ready_in=1 once rst deasserts.
- Factor decode: L_sel values 1, 2, 4, 8, 16 are legal. Any other value is treated as 1.
- Taps per phase: T=N/L.
- IDLE state:
  - ready_in=1.
  - On an edge with valid_in=1 (accept edge A): d shifts (d[0]<=x_input, d[i]<=d[i-1]); L is latched; phase=0, tap=0, acc=0; go to MAC.
- MAC state:
  - ready_in=0.
  - Each edge: acc += d[tap]*h[tap*L+phase], computed in full precision. Products are sign-extended to ACC_WIDTH.
  - When tap!=T-1: tap++.
  - When tap==T-1: y_output<=acc+product, valid_out<=1 for exactly one cycle, acc<=0, tap<=0.
    - If phase==L-1: go to IDLE.
    - Otherwise: phase++ and stay in MAC.
- Latency:
  - Output k (k=1..L) is registered at edge A+k*T; valid_out is high in the cycle following that edge.
  - The last output is registered at edge A+N.
  - ready_in returns high after edge A+N; the next accept is no earlier than edge A+N+1.
  - Maximum input rate is one sample per N+1 cycles, for every L.
- valid_in while ready_in=0: ignored. No sample is taken and nothing is buffered.
- Output ordering: phase 0 first. Output p of input n = sum over j of h[j*L+p]*d[j], where d[0] is the newest sample.
- No gain compensation: a DC gain of L must be built into the coefficients.
- No rounding or saturation. The accumulator cannot overflow for N<=512 with 16-bit operands, so y_output is exact.
- Coefficient writes:
  - Take effect on the edge where coeff_we=1, only in IDLE and only if no input is accepted on that same edge.
  - A write on the same edge as an accept, or while in MAC, is ignored.
- y_output holds its last value between strobes.

Test Plan:
- Impulse, L=4: load h[k]=k and feed x=1000 followed by zeros. First input gives outputs 0, 1000, 2000, 3000 at cycles A+17, A+33, A+49, A+65 (high in the cycle after A+16/32/48/64). Second input (0) gives 4000..7000. After 16 inputs, outputs return to 0.
- Pass-through, L=1: h[0]=1, all other taps 0; stream 5, -7, 32767. Outputs are 5, -7, 32767, one per accept, each 64 cycles after its accept.
- Handshake/throughput, L=2: hold valid_in=1 continuously. ready_in is high for 1 cycle in every 65, accepts occur every 65 cycles, valid_out pulses are 32 cycles apart, and no sample is lost or duplicated.
- Extremes, L=16 (T=4): all h=-32768, x=-32768 for 4 inputs. Each phase output of the 4th input is 4*2^30 = 4294967296 exactly, with no wrap.
- Reset mid-operation, L=4: assert rst during phase 2. valid_out drops immediately and no further strobes occur. After release, ready_in=1, and an impulse input yields all-zero outputs because coefficients were cleared.
- Illegal factor and write rules: L_sel=3 behaves as L=1 (one output per input). A coeff write to h[0]=99 during MAC is ignored. The same write in IDLE with valid_in=0 takes effect; it is verified on the next impulse.

Source files
------------

// File: rtl/fir_interpolator_if.sv
// -----------------------------------------------------------------------------
// fir_interpolator_if
//   Sample / coefficient / output bundle for the polyphase interpolating FIR.
//
//   Signals (direction seen from the filter, i.e. the slave modport):
//     L_sel       in   interpolation factor request (1,2,4,8,16; other -> 1)
//     coeff_we    in   coefficient write strobe
//     coeff_addr  in   coefficient index h[k]
//     coeff_data  in   coefficient value (signed)
//     x_input     in   input sample (signed)
//     valid_in    in   x_input valid
//     ready_in    out  filter can accept a sample
//     y_output    out  output sample (signed, registered)
//     valid_out   out  one-cycle strobe qualifying y_output
//
//   master: the sample source / coefficient loader / output consumer side.
//   slave : the filter itself.
// -----------------------------------------------------------------------------
interface fir_interpolator_if #(
  parameter int WIDTH       = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int N           = 64,
  parameter int ACC_WIDTH   = 41
);

  logic [4:0]                   L_sel;
  logic                         coeff_we;
  logic [$clog2(N)-1:0]         coeff_addr;
  logic signed [COEFF_WIDTH-1:0] coeff_data;
  logic signed [WIDTH-1:0]      x_input;
  logic                         valid_in;
  logic                         ready_in;
  logic signed [ACC_WIDTH-1:0]  y_output;
  logic                         valid_out;

  modport master (
    output L_sel,
    output coeff_we,
    output coeff_addr,
    output coeff_data,
    output x_input,
    output valid_in,
    input  ready_in,
    input  y_output,
    input  valid_out
  );

  modport slave (
    input  L_sel,
    input  coeff_we,
    input  coeff_addr,
    input  coeff_data,
    input  x_input,
    input  valid_in,
    output ready_in,
    output y_output,
    output valid_out
  );

endinterface

// File: rtl/fir_interpolator.sv
// -----------------------------------------------------------------------------
// fir_interpolator
//   Anti-imaging polyphase interpolation FIR. Each accepted input sample
//   produces L output samples (L in {1,2,4,8,16}) using one time-multiplexed
//   multiply-accumulate. Phase p of the current input is
//     y_p = sum_{j=0}^{T-1} h[j*L + p] * d[j],   T = N/L,  d[0] = newest.
//   Phases are emitted in order 0..L-1, one every T cycles, so a full input
//   always occupies exactly N MAC cycles regardless of L.
//
//   Ports:
//     clk   in   single clock, rising edge
//     rst   in   asynchronous active-high reset
//     bus   slave modport of fir_interpolator_if (sample in, coefficient
//           write port, registered output + strobe)
//
//   Arithmetic is exact: full-precision products sign-extended into a
//   ACC_WIDTH accumulator; no rounding, saturation or gain compensation.
// -----------------------------------------------------------------------------
module fir_interpolator #(
  parameter int WIDTH       = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int N           = 64,
  parameter int ACC_WIDTH   = 41
) (
  input  logic              clk,
  input  logic              rst,
  fir_interpolator_if.slave bus
);

  localparam int AW = $clog2(N);
  localparam int PW = WIDTH + COEFF_WIDTH;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MAC  = 1'b1
  } state_t;

  // Map the requested factor to log2(L); anything illegal runs as L=1.
  function automatic logic [2:0] decode_lsh(input logic [4:0] l_req);
    logic [2:0] lsh;
    case (l_req)
      5'd1:    lsh = 3'd0;
      5'd2:    lsh = 3'd1;
      5'd4:    lsh = 3'd2;
      5'd8:    lsh = 3'd3;
      5'd16:   lsh = 3'd4;
      default: lsh = 3'd0;
    endcase
    return lsh;
  endfunction

  state_t                        r_state;
  logic signed [WIDTH-1:0]       r_d [N];
  logic signed [COEFF_WIDTH-1:0] r_h [N];
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic signed [ACC_WIDTH-1:0]   r_y;
  logic [AW-1:0]                 r_tap;
  logic [AW-1:0]                 r_phase;
  logic [2:0]                    r_lsh;
  logic                          r_valid_out;
  logic                          r_ready;

  logic                          w_accept;
  logic                          w_coeff_wr;
  logic [AW-1:0]                 w_h_idx;
  logic [AW-1:0]                 w_tap_last_val;
  logic [AW-1:0]                 w_phase_last_val;
  logic                          w_last_tap;
  logic                          w_last_phase;
  logic signed [PW-1:0]          w_d_ext;
  logic signed [PW-1:0]          w_h_ext;
  logic signed [PW-1:0]          w_prod;
  logic signed [ACC_WIDTH-1:0]   w_prod_ext;
  logic signed [ACC_WIDTH-1:0]   w_sum;

  // A sample is taken only in IDLE; valid_in during MAC is simply dropped.
  assign w_accept   = (r_state == S_IDLE) && bus.valid_in;
  // Coefficient writes lose to a same-edge accept and are locked out in MAC.
  assign w_coeff_wr = (r_state == S_IDLE) && !bus.valid_in && bus.coeff_we;

  // L is a power of two and tap < N/L, phase < L, so shift-or is the exact
  // tap*L + phase without a multiplier and never leaves [0, N).
  assign w_h_idx          = (r_tap << r_lsh) | r_phase;
  assign w_tap_last_val   = AW'((N >> r_lsh) - 1);
  assign w_phase_last_val = AW'((1 << r_lsh) - 1);
  assign w_last_tap       = (r_tap == w_tap_last_val);
  assign w_last_phase     = (r_phase == w_phase_last_val);

  // Operands widened to the full product width before multiplying so the
  // signed product is exact.
  assign w_d_ext    = PW'($signed(r_d[r_tap]));
  assign w_h_ext    = PW'($signed(r_h[w_h_idx]));
  assign w_prod     = w_d_ext * w_h_ext;
  assign w_prod_ext = ACC_WIDTH'(w_prod);
  assign w_sum      = r_acc + w_prod_ext;

  assign bus.ready_in  = r_ready;
  assign bus.y_output  = r_y;
  assign bus.valid_out = r_valid_out;

  // Delay line: shifts in the new sample on every accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_d[i] <= '0;
      end
    end else if (w_accept) begin
      r_d[0] <= bus.x_input;
      for (int i = 1; i < N; i++) begin
        r_d[i] <= r_d[i-1];
      end
    end
  end

  // Coefficient memory: run-time loadable, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_h[i] <= '0;
      end
    end else if (w_coeff_wr) begin
      r_h[bus.coeff_addr] <= bus.coeff_data;
    end
  end

  // Control FSM plus MAC datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_y         <= '0;
      r_tap       <= '0;
      r_phase     <= '0;
      r_lsh       <= 3'd0;
      r_valid_out <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_valid_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.valid_in) begin
            r_lsh   <= decode_lsh(bus.L_sel);
            r_phase <= '0;
            r_tap   <= '0;
            r_acc   <= '0;
            r_ready <= 1'b0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          if (w_last_tap) begin
            // Final tap of this phase: publish acc + product directly so the
            // phase costs exactly T cycles.
            r_y         <= w_sum;
            r_valid_out <= 1'b1;
            r_acc       <= '0;
            r_tap       <= '0;
            if (w_last_phase) begin
              r_phase <= '0;
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_phase <= r_phase + AW'(1);
            end
          end else begin
            r_acc <= w_sum;
            r_tap <= r_tap + AW'(1);
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_interpolator.sv
// -----------------------------------------------------------------------------
// tb_fir_interpolator
//   Directed self-checking bench for fir_interpolator. Expected values are
//   hand-derived from the polyphase equation y_p = sum_j h[j*L+p]*d[j].
// -----------------------------------------------------------------------------
module tb_fir_interpolator;

  localparam int WIDTH       = 16;
  localparam int COEFF_WIDTH = 16;
  localparam int N           = 64;
  localparam int ACC_WIDTH   = 41;
  localparam int AW          = $clog2(N);

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  longint out_q[$];
  int     out_t[$];

  always #5 clk = ~clk;

  fir_interpolator_if #(
    .WIDTH(WIDTH), .COEFF_WIDTH(COEFF_WIDTH), .N(N), .ACC_WIDTH(ACC_WIDTH)
  ) bus ();

  fir_interpolator #(
    .WIDTH(WIDTH), .COEFF_WIDTH(COEFF_WIDTH), .N(N), .ACC_WIDTH(ACC_WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Edge counter: value read #1 after an edge equals that edge's index.
  always @(posedge clk) cyc <= cyc + 1;

  // Output collector, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst && bus.valid_out) begin
      out_q.push_back(longint'(bus.y_output));
      out_t.push_back(cyc);
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic longint q_at(input int i);
    if (i < out_q.size()) return out_q[i];
    else return -1;
  endfunction

  function automatic int t_at(input int i);
    if (i < out_t.size()) return out_t[i];
    else return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_out();
    out_q.delete();
    out_t.delete();
  endtask

  task automatic load_coeff(input logic [AW-1:0] addr, input logic signed [COEFF_WIDTH-1:0] data);
    bus.coeff_we   = 1'b1;
    bus.coeff_addr = addr;
    bus.coeff_data = data;
    tick();
    bus.coeff_we   = 1'b0;
  endtask

  // Waits (bounded) for ready_in, then presents one sample for one edge.
  task automatic send(input logic signed [WIDTH-1:0] x, input logic [4:0] lsel, output int acc_cyc);
    int k = 0;
    while (!bus.ready_in && k < 4*N) begin
      tick();
      k++;
    end
    bus.x_input  = x;
    bus.L_sel    = lsel;
    bus.valid_in = 1'b1;
    tick();
    acc_cyc      = cyc;
    bus.valid_in = 1'b0;
  endtask

  // Waits (bounded) for the filter to return to IDLE, plus one cycle so the
  // collector has seen the final strobe.
  task automatic wait_done();
    int k = 0;
    while (!bus.ready_in && k < 4*N) begin
      tick();
      k++;
    end
    check_val("done_ready", longint'(bus.ready_in), 1);
    tick();
  endtask

  initial begin
    int acc;
    int a[4];
    longint pt[3];
    longint hs[4];

    rst            = 1'b1;
    bus.valid_in   = 1'b0;
    bus.x_input    = '0;
    bus.L_sel      = 5'd1;
    bus.coeff_we   = 1'b0;
    bus.coeff_addr = '0;
    bus.coeff_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check_val("rst_ready", longint'(bus.ready_in), 1);
    check_val("rst_valid", longint'(bus.valid_out), 0);
    check_val("rst_y", longint'(bus.y_output), 0);

    // Impulse, L=4, h[k]=k: input n (impulse n inputs back) gives (4n+p)*1000
    for (int k = 0; k < N; k++) load_coeff(AW'(k), COEFF_WIDTH'(k));
    for (int n = 0; n < 17; n++) begin
      clear_out();
      send((n == 0) ? 16'sd1000 : 16'sd0, 5'd4, acc);
      wait_done();
      check_val($sformatf("imp_cnt_n%0d", n), out_q.size(), 4);
      for (int p = 0; p < 4; p++) begin
        check_val($sformatf("imp_val_n%0d_p%0d", n, p), q_at(p),
                  (n < 16) ? longint'((4*n + p) * 1000) : 64'sd0);
        if (n == 0) check_val($sformatf("imp_lat_p%0d", p), t_at(p) - acc, 16*(p+1));
      end
    end

    // Pass-through, L=1, h[0]=1
    load_coeff(AW'(0), 16'sd1);
    for (int k = 1; k < N; k++) load_coeff(AW'(k), 16'sd0);
    pt[0] = 5; pt[1] = -7; pt[2] = 32767;
    clear_out();
    for (int i = 0; i < 3; i++) begin
      send(WIDTH'(pt[i]), 5'd1, acc);
      wait_done();
      check_val($sformatf("pt_cnt_%0d", i), out_q.size(), i + 1);
      check_val($sformatf("pt_val_%0d", i), q_at(i), pt[i]);
      check_val($sformatf("pt_lat_%0d", i), t_at(i) - acc, 64);
    end

    // Handshake, L=2, valid_in held high: outputs x then 0 per input
    hs[0] = 100; hs[1] = -200; hs[2] = 300; hs[3] = -400;
    clear_out();
    bus.L_sel    = 5'd2;
    bus.valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int k = 0;
      bus.x_input = WIDTH'(hs[i]);
      while (!bus.ready_in && k < 4*N) begin
        tick();
        k++;
      end
      check_val($sformatf("hs_ready_%0d", i), longint'(bus.ready_in), 1);
      tick();
      a[i] = cyc;
      if (i == 0) check_val("hs_busy", longint'(bus.ready_in), 0);
    end
    bus.valid_in = 1'b0;
    wait_done();
    check_val("hs_cnt", out_q.size(), 8);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("hs_val_%0d_p0", i), q_at(2*i), hs[i]);
      check_val($sformatf("hs_val_%0d_p1", i), q_at(2*i+1), 0);
      check_val($sformatf("hs_lat_%0d", i), t_at(2*i) - a[i], 32);
      check_val($sformatf("hs_gap_%0d", i), t_at(2*i+1) - t_at(2*i), 32);
      if (i > 0) check_val($sformatf("hs_acc_gap_%0d", i), a[i] - a[i-1], 65);
    end

    // Extremes, L=16: four taps of (-32768)*(-32768) per phase
    for (int k = 0; k < N; k++) load_coeff(AW'(k), 16'sh8000);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) clear_out();
      send(16'sh8000, 5'd16, acc);
      wait_done();
    end
    check_val("ext_cnt", out_q.size(), 16);
    for (int p = 0; p < 16; p++) begin
      check_val($sformatf("ext_val_p%0d", p), q_at(p), 64'sd4294967296);
    end

    // Reset at the start of phase 2 (L=4), while the phase-1 strobe is high
    clear_out();
    send(16'sd1000, 5'd4, acc);
    repeat (32) tick();
    check_val("rst_pre_valid", longint'(bus.valid_out), 1);
    rst = 1'b1;
    #1;
    check_val("rst_mid_valid", longint'(bus.valid_out), 0);
    check_val("rst_mid_y", longint'(bus.y_output), 0);
    repeat (2) tick();
    rst = 1'b0;
    clear_out();
    repeat (70) tick();
    check_val("rst_post_strobes", out_q.size(), 0);
    check_val("rst_post_ready", longint'(bus.ready_in), 1);
    send(16'sd1000, 5'd4, acc);
    wait_done();
    check_val("rst_imp_cnt", out_q.size(), 4);
    for (int p = 0; p < 4; p++) begin
      check_val($sformatf("rst_imp_p%0d", p), q_at(p), 0);
    end

    // Illegal L_sel=3 runs as L=1; write during MAC is ignored
    clear_out();
    send(16'sd7, 5'd3, acc);
    repeat (10) tick();
    bus.coeff_we   = 1'b1;
    bus.coeff_addr = AW'(0);
    bus.coeff_data = 16'sd99;
    tick();
    bus.coeff_we   = 1'b0;
    wait_done();
    repeat (70) tick();
    check_val("ill_cnt", out_q.size(), 1);
    check_val("ill_val", q_at(0), 0);
    check_val("ill_lat", t_at(0) - acc, 64);

    // Same write in IDLE takes effect: d = {2, 7, 1000, ...}, only h[0]=99
    load_coeff(AW'(0), 16'sd99);
    clear_out();
    send(16'sd2, 5'd3, acc);
    wait_done();
    check_val("wr_idle_cnt", out_q.size(), 1);
    check_val("wr_idle_val", q_at(0), 198);

    // Write on the accept edge is ignored: h[0] stays 99
    clear_out();
    bus.coeff_we   = 1'b1;
    bus.coeff_addr = AW'(0);
    bus.coeff_data = 16'sd55;
    send(16'sd1, 5'd3, acc);
    bus.coeff_we   = 1'b0;
    wait_done();
    check_val("wr_acc_cnt", out_q.size(), 1);
    check_val("wr_acc_val", q_at(0), 99);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
